// File: rtl/mux2_share_arbiter.sv
// mux2_share_arbiter
//   Shares one 2:1 data mux between requesters A and B. Arbitration is
//   round-robin, and each grant holds for a bounded burst. The muxed beat is
//   registered onto a single valid/ready stream. The block also counts select
//   switches so that mux activity can be matched to VCD toggle counts.
// Ports
//   clk, rst              clock and synchronous active-high reset
//   req_a/data_a/ack_a    requester A (ack_a is combinational)
//   req_b/data_b/ack_b    requester B (ack_b is combinational)
//   out_valid/out_data    registered output beat
//   out_ready             downstream accept
//   sel                   registered mux select (0 = A, 1 = B)
//   switch_cnt            saturating count of sel changes since reset
module mux2_share_arbiter #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              ack_b,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              sel,
    output logic [CNT_W-1:0]  switch_cnt
);

    localparam int unsigned BCNT_W = $clog2(BURST_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                sel_q, sel_d;
    logic                last_grant_q, last_grant_d;   // 0 = A, 1 = B
    logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]    switch_cnt_q, switch_cnt_d;

    logic                space;
    logic                acc_a, acc_b;
    logic [BCNT_W-1:0]   beat_inc;
    logic                burst_done;

    // Output register can take a beat when empty or draining this cycle
    assign space = !out_valid_q || out_ready;
    assign ack_a = (state_q == GNT_A) && space;
    assign ack_b = (state_q == GNT_B) && space;
    assign acc_a = req_a && ack_a;
    assign acc_b = req_b && ack_b;

    assign beat_inc   = beat_cnt_q + BCNT_W'(1);
    assign burst_done = (beat_inc == BCNT_W'(BURST_MAX));

    // Arbitration FSM next state
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        case (state_q)
            IDLE: begin
                // With both requesting, the side that did not hold the last grant wins
                if ((req_a && req_b && last_grant_q) || (req_a && !req_b)) begin
                    state_d    = GNT_A;
                    sel_d      = 1'b0;
                    beat_cnt_d = '0;
                end else if (req_b) begin
                    state_d    = GNT_B;
                    sel_d      = 1'b1;
                    beat_cnt_d = '0;
                end
            end
            GNT_A: begin
                if (!req_a) begin
                    last_grant_d = 1'b0;
                    beat_cnt_d   = '0;
                    if (req_b) begin
                        state_d = GNT_B;
                        sel_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (acc_a) begin
                    if (burst_done && req_b) begin
                        last_grant_d = 1'b0;
                        state_d      = GNT_B;
                        sel_d        = 1'b1;
                        beat_cnt_d   = '0;
                    end else if (burst_done) begin
                        // No contention: start a fresh burst on the same side
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_inc;
                    end
                end
            end
            GNT_B: begin
                if (!req_b) begin
                    last_grant_d = 1'b1;
                    beat_cnt_d   = '0;
                    if (req_a) begin
                        state_d = GNT_A;
                        sel_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (acc_b) begin
                    if (burst_done && req_a) begin
                        last_grant_d = 1'b1;
                        state_d      = GNT_A;
                        sel_d        = 1'b0;
                        beat_cnt_d   = '0;
                    end else if (burst_done) begin
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_inc;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output stage: load on accept, clear on drain, otherwise hold
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        switch_cnt_d = switch_cnt_q;
        if (acc_a) begin
            out_valid_d = 1'b1;
            out_data_d  = data_a;
        end else if (acc_b) begin
            out_valid_d = 1'b1;
            out_data_d  = data_b;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if ((sel_d != sel_q) && (switch_cnt_q != {CNT_W{1'b1}})) begin
            switch_cnt_d = switch_cnt_q + CNT_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            switch_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            switch_cnt_q <= switch_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign sel        = sel_q;
    assign switch_cnt = switch_cnt_q;

endmodule

// File: tb/tb_mux2_share_arbiter.sv
// tb_mux2_share_arbiter
//   Cycle table of inputs and expected acks/sel/valid/switch count for the
//   default instance, with a CNT_W=2 instance on the same inputs to show
//   counter saturation. Output beats go through a data scoreboard.
module tb_mux2_share_arbiter;

    logic       clk;
    logic       rst;
    logic       req_a, req_b, out_ready;
    logic [7:0] data_a, data_b;

    logic        ack_a, ack_b, out_valid, sel;
    logic [7:0]  out_data;
    logic [15:0] switch_cnt;

    logic       ack_a_s, ack_b_s, out_valid_s, sel_s;
    logic [7:0] out_data_s;
    logic [1:0] switch_cnt_s;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mux2_share_arbiter #(.DATA_W(8), .BURST_MAX(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel(sel), .switch_cnt(switch_cnt)
    );

    mux2_share_arbiter #(.DATA_W(8), .BURST_MAX(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .req_a(req_a), .data_a(data_a), .ack_a(ack_a_s),
        .req_b(req_b), .data_b(data_b), .ack_b(ack_b_s),
        .out_valid(out_valid_s), .out_data(out_data_s), .out_ready(out_ready),
        .sel(sel_s), .switch_cnt(switch_cnt_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic        ra;
        logic [7:0]  da;
        logic        rb;
        logic [7:0]  db;
        logic        rdy;
        logic        e_ack_a;
        logic        e_ack_b;
        logic        e_sel;
        logic        e_valid;
        int unsigned e_cnt;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic ra, input logic [7:0] da,
                       input logic rb, input logic [7:0] db, input logic rdy,
                       input logic eaa, input logic eab, input logic es,
                       input logic ev, input int unsigned ec);
        vec_t v;
        v.rst = r; v.ra = ra; v.da = da; v.rb = rb; v.db = db; v.rdy = rdy;
        v.e_ack_a = eaa; v.e_ack_b = eab; v.e_sel = es; v.e_valid = ev; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    initial begin
        int unsigned sat_exp;
        bit          seen;

        // rst ra  da   rb  db   rdy | ackA ackB sel valid cnt
        add(1, 1, 8'h00, 1, 8'h00, 1,  0, 0, 0, 0, 0);  // reset held, both requesting
        add(0, 1, 8'h11, 0, 8'h00, 1,  0, 0, 0, 0, 0);  // single requester A
        add(0, 1, 8'h11, 0, 8'h00, 1,  1, 0, 0, 0, 0);
        add(0, 1, 8'h12, 0, 8'h00, 1,  1, 0, 0, 1, 0);
        add(0, 1, 8'h13, 0, 8'h00, 1,  1, 0, 0, 1, 0);
        add(0, 1, 8'h14, 0, 8'h00, 1,  1, 0, 0, 1, 0);
        add(0, 1, 8'h15, 0, 8'h00, 1,  1, 0, 0, 1, 0);
        add(0, 1, 8'h16, 0, 8'h00, 1,  1, 0, 0, 1, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1,  1, 0, 0, 1, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 0);
        add(0, 1, 8'h21, 1, 8'h31, 1,  0, 0, 0, 0, 0);  // contention, last grant was A
        add(0, 1, 8'h21, 1, 8'h31, 1,  0, 1, 1, 0, 1);
        add(0, 1, 8'h21, 1, 8'h32, 1,  0, 1, 1, 1, 1);
        add(0, 1, 8'h21, 1, 8'h33, 1,  0, 1, 1, 1, 1);
        add(0, 1, 8'h21, 1, 8'h34, 1,  0, 1, 1, 1, 1);
        add(0, 1, 8'h21, 1, 8'h35, 1,  1, 0, 0, 1, 2);
        add(0, 1, 8'h22, 1, 8'h35, 1,  1, 0, 0, 1, 2);
        add(0, 1, 8'h23, 1, 8'h35, 1,  1, 0, 0, 1, 2);
        add(0, 1, 8'h24, 1, 8'h35, 1,  1, 0, 0, 1, 2);
        add(0, 1, 8'h25, 1, 8'h35, 1,  0, 1, 1, 1, 3);
        add(0, 1, 8'h25, 1, 8'h36, 0,  0, 0, 1, 1, 3);  // backpressure x3
        add(0, 1, 8'h25, 1, 8'h36, 0,  0, 0, 1, 1, 3);
        add(0, 1, 8'h25, 1, 8'h36, 0,  0, 0, 1, 1, 3);
        add(0, 1, 8'h25, 1, 8'h36, 1,  0, 1, 1, 1, 3);  // drain + accept same cycle
        add(0, 1, 8'h25, 0, 8'h36, 1,  0, 1, 1, 1, 3);  // early release of B
        add(0, 1, 8'h25, 0, 8'h00, 1,  1, 0, 0, 0, 4);
        add(0, 1, 8'h26, 1, 8'h37, 1,  1, 0, 0, 1, 4);
        add(0, 1, 8'h27, 1, 8'h37, 1,  1, 0, 0, 1, 4);
        add(0, 1, 8'h28, 1, 8'h37, 1,  1, 0, 0, 1, 4);  // 4th A beat after restart
        add(0, 1, 8'h29, 1, 8'h37, 1,  0, 1, 1, 1, 5);
        add(0, 1, 8'h29, 0, 8'h37, 1,  0, 1, 1, 1, 5);
        add(0, 1, 8'h29, 0, 8'h00, 1,  1, 0, 0, 0, 6);
        add(1, 1, 8'h29, 0, 8'h00, 0,  0, 0, 0, 1, 6);  // reset mid GNT_A
        add(0, 1, 8'h29, 0, 8'h00, 1,  0, 0, 0, 0, 0);
        add(0, 1, 8'h29, 0, 8'h00, 1,  1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1,  1, 0, 0, 1, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 0);
        add(0, 1, 8'h41, 1, 8'h51, 1,  0, 0, 0, 0, 0);  // A first after reset
        add(0, 1, 8'h41, 1, 8'h51, 1,  1, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1,  1, 0, 0, 1, 0);
        add(0, 0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 0, 0);

        rst = 1'b1; req_a = 1'b1; req_b = 1'b1; data_a = 8'h00; data_b = 8'h00; out_ready = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            rst = vecs[i].rst; req_a = vecs[i].ra; data_a = vecs[i].da;
            req_b = vecs[i].rb; data_b = vecs[i].db; out_ready = vecs[i].rdy;
            @(negedge clk);
            sat_exp = (vecs[i].e_cnt > 3) ? 3 : vecs[i].e_cnt;
            check("ack_a", 32'(ack_a), 32'(vecs[i].e_ack_a));
            check("ack_b", 32'(ack_b), 32'(vecs[i].e_ack_b));
            check("sel", 32'(sel), 32'(vecs[i].e_sel));
            check("out_valid", 32'(out_valid), 32'(vecs[i].e_valid));
            check("switch_cnt", 32'(switch_cnt), vecs[i].e_cnt);
            check("sat_ack_a", 32'(ack_a_s), 32'(vecs[i].e_ack_a));
            check("sat_ack_b", 32'(ack_b_s), 32'(vecs[i].e_ack_b));
            check("sat_sel", 32'(sel_s), 32'(vecs[i].e_sel));
            check("sat_valid", 32'(out_valid_s), 32'(vecs[i].e_valid));
            check("sat_switch_cnt", 32'(switch_cnt_s), sat_exp);
            // Scoreboard: the front entry is the beat held in the output register
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'(sb_q.size()), 32'd1);
                end else begin
                    check("out_data", 32'(out_data), 32'(sb_q[0]));
                    check("sat_out_data", 32'(out_data_s), 32'(sb_q[0]));
                    if (out_ready) void'(sb_q.pop_front());
                end
            end
            if (vecs[i].rst) begin
                sb_q.delete();
            end else begin
                if (vecs[i].ra && vecs[i].e_ack_a) sb_q.push_back(vecs[i].da);
                if (vecs[i].rb && vecs[i].e_ack_b) sb_q.push_back(vecs[i].db);
            end
            @(posedge clk); #1;
        end
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        // Lone B request after reset: bounded waits for grant and output beat
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_b = 1'b1; data_b = 8'h5A;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            if (ack_b) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("b_grant_seen", 32'(seen), 32'd1);
        req_b = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("b_beat_seen", 32'(seen), 32'd1);
        check("b_beat_data", 32'(out_data), 32'h5A);
        check("b_sel", 32'(sel), 32'd1);
        check("b_switch_cnt", 32'(switch_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
